// File: rtl/control_pkg.sv
// control_pkg
// Shared definitions for the multicycle RISC-V control unit and the ALU.
// Contents:
//   state_t          - FSM state enumeration
//   OP_*             - supported major opcodes
//   ALU_*            - ALU control codes (shared with the ALU)
//   BR_*             - branch funct3 codes carried on alu_control in branch mode
//   RES_*/SRCA_*/SRCB_*/IMM_* - datapath mux select encodings
//   imm_src_of()     - immediate format for an opcode
//   branch_f3_legal()- whether a branch funct3 is supported
package control_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;

    // Immediate format depends only on the opcode; unknown opcodes fall back to I.
    function automatic logic [2:0] imm_src_of(input logic [6:0] opcode);
        case (opcode)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

    function automatic logic branch_f3_legal(input logic [2:0] funct3);
        case (funct3)
            BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// mc_control_fsm_if
// Bundles the instruction fields, datapath flags and every control output
// between the multicycle control unit and the datapath.
//   master - the control FSM: reads opcode/funct3/funct7b5/zero/mem_ready,
//            drives enables, mux selects, ALU control, instr_done and trap.
//   slave  - the datapath side of the same wires.
interface mc_control_fsm_if;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;

    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] imm_src;
    logic [2:0] alu_control;
    logic       alu_op;
    logic       instr_done;
    logic       trap;

    modport master (
        input  opcode, funct3, funct7b5, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, imm_src,
               alu_control, alu_op, instr_done, trap
    );

    modport slave (
        output opcode, funct3, funct7b5, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, imm_src,
               alu_control, alu_op, instr_done, trap
    );

endinterface

// File: rtl/alu_decoder.sv
// alu_decoder
// Combinational ALU control decode for R-type, I-type and branch instructions.
// Inputs:  opcode, funct3, funct7b5 (instruction bit 30)
// Outputs: alu_control - ALU operation (branch: funct3 passed through)
//          illegal     - funct3 not supported for this R/I/branch opcode
module alu_decoder
    import control_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [2:0] alu_control,
    output logic       illegal
);

    // Bit 30 only distinguishes sub from add for R-type; addi ignores it since
    // bit 30 is part of the immediate there.
    always_comb begin
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        if (opcode == OP_BRANCH) begin
            alu_control = funct3;
            illegal     = !branch_f3_legal(funct3);
        end else if (opcode == OP_RTYPE || opcode == OP_ITYPE) begin
            case (funct3)
                3'b000:  alu_control = (opcode == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
                3'b010:  alu_control = ALU_SLT;
                3'b110:  alu_control = ALU_OR;
                3'b111:  alu_control = ALU_AND;
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm
// Multicycle control unit: sequences fetch/decode/execute/memory/writeback
// for lw, sw, R-type, I-type ALU, branches and jal; anything else parks the
// FSM in a sticky TRAP state until reset.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - mc_control_fsm_if.master: instruction fields, zero, mem_ready in;
//         enables, mux selects, ALU control, instr_done and trap out
module mc_control_fsm
    import control_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    mc_control_fsm_if.master       bus
);

    state_t     state;
    logic [2:0] dec_alu_control;
    logic       dec_illegal;

    logic       pc_write_c;
    logic       mem_write_c;
    logic       ir_write_c;
    logic       reg_write_c;
    logic       instr_done_c;
    logic       trap_c;

    alu_decoder u_alu_decoder (
        .opcode      (bus.opcode),
        .funct3      (bus.funct3),
        .funct7b5    (bus.funct7b5),
        .alu_control (dec_alu_control),
        .illegal     (dec_illegal)
    );

    // State register and next-state logic; unsupported opcodes or funct3
    // values are caught in DECODE so no side effect is ever issued for them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:    if (bus.mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    case (bus.opcode)
                        OP_LOAD, OP_STORE: state <= S_MEMADR;
                        OP_RTYPE:  state <= dec_illegal ? S_TRAP : S_EXECUTER;
                        OP_ITYPE:  state <= dec_illegal ? S_TRAP : S_EXECUTEI;
                        OP_BRANCH: state <= dec_illegal ? S_TRAP : S_BRANCH;
                        OP_JAL:    state <= S_JAL;
                        default:   state <= S_TRAP;
                    endcase
                end
                S_MEMADR:   state <= (bus.opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (bus.mem_ready) state <= S_MEMWB;
                S_MEMWB:    state <= S_FETCH;
                S_MEMWRITE: if (bus.mem_ready) state <= S_FETCH;
                S_EXECUTER: state <= S_ALUWB;
                S_EXECUTEI: state <= S_ALUWB;
                S_ALUWB:    state <= S_FETCH;
                S_BRANCH:   state <= S_FETCH;
                S_JAL:      state <= S_ALUWB;
                S_TRAP:     state <= S_TRAP;
                default:    state <= S_FETCH;
            endcase
        end
    end

    // Per-state outputs. Most are pure functions of the state; the FETCH
    // enables, the branch pc_write and the sw completion pulse also follow
    // mem_ready/zero in the same cycle.
    always_comb begin
        pc_write_c       = 1'b0;
        mem_write_c      = 1'b0;
        ir_write_c       = 1'b0;
        reg_write_c      = 1'b0;
        instr_done_c     = 1'b0;
        trap_c           = 1'b0;
        bus.adr_src      = 1'b0;
        bus.result_src   = RES_ALUOUT;
        bus.alu_src_a    = SRCA_PC;
        bus.alu_src_b    = SRCB_RD2;
        bus.alu_control  = ALU_ADD;
        bus.alu_op       = 1'b0;
        case (state)
            S_FETCH: begin
                bus.alu_src_b  = SRCB_FOUR;
                bus.result_src = RES_ALURESULT;
                ir_write_c     = bus.mem_ready;
                pc_write_c     = bus.mem_ready;
            end
            S_DECODE: begin
                bus.alu_src_a = SRCA_OLDPC;
                bus.alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                bus.alu_src_a = SRCA_RD1;
                bus.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                bus.adr_src = 1'b1;
            end
            S_MEMWB: begin
                bus.result_src = RES_DATA;
                reg_write_c    = 1'b1;
                instr_done_c   = 1'b1;
            end
            S_MEMWRITE: begin
                bus.adr_src  = 1'b1;
                mem_write_c  = 1'b1;
                instr_done_c = bus.mem_ready;
            end
            S_EXECUTER: begin
                bus.alu_src_a   = SRCA_RD1;
                bus.alu_control = dec_alu_control;
            end
            S_EXECUTEI: begin
                bus.alu_src_a   = SRCA_RD1;
                bus.alu_src_b   = SRCB_IMM;
                bus.alu_control = dec_alu_control;
            end
            S_ALUWB: begin
                reg_write_c  = 1'b1;
                instr_done_c = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a   = SRCA_RD1;
                bus.alu_op      = 1'b1;
                bus.alu_control = bus.funct3;
                pc_write_c      = ~bus.zero;
                instr_done_c    = 1'b1;
            end
            S_JAL: begin
                bus.alu_src_a = SRCA_OLDPC;
                bus.alu_src_b = SRCB_FOUR;
                pc_write_c    = 1'b1;
            end
            S_TRAP: begin
                trap_c = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Reset masks every side effect in the reset cycle itself, so an access
    // that is stalled when reset arrives is never completed.
    assign bus.pc_write   = pc_write_c   & ~rst;
    assign bus.mem_write  = mem_write_c  & ~rst;
    assign bus.ir_write   = ir_write_c   & ~rst;
    assign bus.reg_write  = reg_write_c  & ~rst;
    assign bus.instr_done = instr_done_c & ~rst;
    assign bus.trap       = trap_c       & ~rst;
    assign bus.imm_src    = imm_src_of(bus.opcode);

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm
// Drives instructions into mc_control_fsm with random memory stalls and
// branch flags, and compares each retired instruction against a reference
// model of its expected length and side effects.
module tb_mc_control_fsm;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct {
        int    len;
        int    n_pc;
        int    n_ir;
        int    n_reg;
        int    n_mem;
        int    n_aluop;
        int    exec_alu;
        string name;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t sb[$];

    mc_control_fsm_if bus_if();

    mc_control_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every comparison goes through here so the counters stay consistent.
    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // ALU operation an R/I instruction should request.
    function automatic int refAlu(input bit is_r, input logic [2:0] f3, input logic f7);
        if (f3 == 3'd0) return (is_r && f7) ? 1 : 0;
        if (f3 == 3'd2) return 5;
        if (f3 == 3'd6) return 3;
        return 2;
    endfunction

    function automatic bit refLegal(input logic [6:0] op, input logic [2:0] f3);
        if (op == OPC_LOAD || op == OPC_STORE || op == OPC_JAL) return 1'b1;
        if (op == OPC_R || op == OPC_I) return (f3 == 3'd0 || f3 == 3'd2 || f3 == 3'd6 || f3 == 3'd7);
        if (op == OPC_BRANCH) return !(f3 == 3'd2 || f3 == 3'd3);
        return 1'b0;
    endfunction

    function automatic int refImm(input logic [6:0] op);
        if (op == OPC_STORE) return 1;
        if (op == OPC_BRANCH) return 2;
        if (op == OPC_JAL) return 3;
        return 0;
    endfunction

    // Whole-instruction summary: cycle count and how many cycles each enable is up.
    function automatic exp_t refModel(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                      input logic z, input int fs, input int ms);
        exp_t e;
        e.n_ir = 1;
        e.n_pc = 1;
        e.n_reg = 0;
        e.n_mem = 0;
        e.n_aluop = 0;
        e.exec_alu = 0;
        e.len = 0;
        e.name = "";
        if (op == OPC_LOAD) begin
            e.len = 5 + fs + ms;
            e.n_reg = 1;
        end else if (op == OPC_STORE) begin
            e.len = 4 + fs + ms;
            e.n_mem = 1 + ms;
        end else if (op == OPC_R || op == OPC_I) begin
            e.len = 4 + fs;
            e.n_reg = 1;
            e.exec_alu = refAlu(op == OPC_R, f3, f7);
        end else if (op == OPC_BRANCH) begin
            e.len = 3 + fs;
            e.n_pc = z ? 1 : 2;
            e.n_aluop = 1;
            e.exec_alu = int'(f3);
        end else begin
            e.len = 4 + fs;
            e.n_pc = 2;
            e.n_reg = 1;
            e.exec_alu = -1;
        end
        return e;
    endfunction

    // Monitor: accumulates activity per instruction and checks it against the
    // oldest pending expectation whenever instr_done is seen.
    initial begin
        int   cyc, n_pc, n_ir, n_reg, n_mem, n_aluop, last_alu;
        exp_t e;
        cyc = 0; n_pc = 0; n_ir = 0; n_reg = 0; n_mem = 0; n_aluop = 0; last_alu = -1;
        forever begin
            @(negedge clk);
            if (rst) begin
                cyc = 0; n_pc = 0; n_ir = 0; n_reg = 0; n_mem = 0; n_aluop = 0; last_alu = -1;
            end else begin
                cyc++;
                n_pc    += int'(bus_if.pc_write);
                n_ir    += int'(bus_if.ir_write);
                n_reg   += int'(bus_if.reg_write);
                n_mem   += int'(bus_if.mem_write);
                n_aluop += int'(bus_if.alu_op);
                if (bus_if.alu_src_a == 2'b10) last_alu = int'(bus_if.alu_control);
                if (bus_if.instr_done) begin
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_instr_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        checkOutput({e.name, "_cycles"}, cyc, e.len);
                        checkOutput({e.name, "_pc_write"}, n_pc, e.n_pc);
                        checkOutput({e.name, "_ir_write"}, n_ir, e.n_ir);
                        checkOutput({e.name, "_reg_write"}, n_reg, e.n_reg);
                        checkOutput({e.name, "_mem_write"}, n_mem, e.n_mem);
                        checkOutput({e.name, "_alu_op"}, n_aluop, e.n_aluop);
                        checkOutput({e.name, "_alu_control"}, last_alu, e.exec_alu);
                    end
                    cyc = 0; n_pc = 0; n_ir = 0; n_reg = 0; n_mem = 0; n_aluop = 0; last_alu = -1;
                end
            end
        end
    end

    // One reset cycle; nothing may be enabled while rst is high.
    task automatic doReset();
        rst = 1'b1;
        bus_if.mem_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        checkOutput("reset_enables",
                    int'({bus_if.pc_write, bus_if.ir_write, bus_if.reg_write, bus_if.mem_write}), 0);
        checkOutput("reset_instr_done", int'(bus_if.instr_done), 0);
        checkOutput("reset_trap", int'(bus_if.trap), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Runs one instruction from its first FETCH cycle. fs = FETCH stall cycles,
    // ms = stall cycles on the lw/sw data access. Illegal instructions are
    // watched for ten cycles in the trap and then cleared by reset.
    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                 input logic z, input int fs, input int ms, input string name);
        exp_t e;
        bit   legal;
        bit   has_mem;
        bit   done;
        int   trap_cycles;
        int   en_cycles;
        int   memcyc;
        legal   = refLegal(op, f3);
        has_mem = (op == OPC_LOAD) || (op == OPC_STORE);
        memcyc  = fs + 3;
        if (legal) begin
            e = refModel(op, f3, f7, z, fs, ms);
            e.name = name;
            sb.push_back(e);
        end
        bus_if.opcode   = op;
        bus_if.funct3   = f3;
        bus_if.funct7b5 = f7;
        bus_if.zero     = z;
        done = 1'b0;
        trap_cycles = 0;
        en_cycles = 0;
        for (int k = 0; k < 60; k++) begin
            if (k < fs) bus_if.mem_ready = 1'b0;
            else if (k == fs) bus_if.mem_ready = 1'b1;
            else if (has_mem && k >= memcyc && k < memcyc + ms) bus_if.mem_ready = 1'b0;
            else if (has_mem && k == memcyc + ms) bus_if.mem_ready = 1'b1;
            else bus_if.mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (k == 0) begin
                checkOutput({name, "_fetch_srcb"}, int'(bus_if.alu_src_b), 2);
                checkOutput({name, "_fetch_adr_src"}, int'(bus_if.adr_src), 0);
                checkOutput({name, "_fetch_ir_write"}, int'(bus_if.ir_write), int'(bus_if.mem_ready));
                checkOutput({name, "_fetch_trap"}, int'(bus_if.trap), 0);
                checkOutput({name, "_imm_src"}, int'(bus_if.imm_src), refImm(op));
            end
            if (has_mem && ms > 0 && k == memcyc)
                checkOutput({name, "_stall_adr_src"}, int'(bus_if.adr_src), 1);
            if (legal) begin
                if (bus_if.instr_done) done = 1'b1;
            end else if (k >= fs + 2) begin
                trap_cycles += int'(bus_if.trap);
                en_cycles += int'(bus_if.pc_write | bus_if.ir_write | bus_if.reg_write | bus_if.mem_write);
            end
            @(posedge clk);
            #1;
            if (legal ? done : (k == fs + 11)) break;
        end
        if (legal && !done) begin
            checkOutput({name, "_timeout"}, 0, 1);
            sb.delete();
            doReset();
        end
        if (!legal) begin
            checkOutput({name, "_trap_cycles"}, trap_cycles, 10);
            checkOutput({name, "_trap_enables"}, en_cycles, 0);
            doReset();
        end
    endtask

    // sw held in a MEMWRITE stall, then reset arrives together with mem_ready.
    task automatic swResetTest();
        bus_if.opcode   = OPC_STORE;
        bus_if.funct3   = 3'b010;
        bus_if.funct7b5 = 1'b0;
        bus_if.zero     = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus_if.mem_ready = (k == 0) ? 1'b1 : ((k >= 3) ? 1'b0 : 1'($urandom_range(0, 1)));
            @(negedge clk);
            if (k == 4) checkOutput("sw_stall_mem_write", int'(bus_if.mem_write), 1);
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        bus_if.mem_ready = 1'b1;
        @(negedge clk);
        checkOutput("sw_reset_mem_write", int'(bus_if.mem_write), 0);
        checkOutput("sw_reset_instr_done", int'(bus_if.instr_done), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Hard stop in case anything above stops advancing.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed cases first, then a randomized instruction stream.
    initial begin
        logic [2:0] alu_f3 [4];
        logic [2:0] bad_f3 [4];
        logic [2:0] br_f3 [6];
        logic [6:0] op;
        logic [2:0] f3;
        int         kind;
        int         sub;
        total = 0;
        bad = 0;
        alu_f3 = '{3'd0, 3'd2, 3'd6, 3'd7};
        bad_f3 = '{3'd1, 3'd3, 3'd4, 3'd5};
        br_f3  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        rst = 1'b1;
        bus_if.opcode = 7'd0;
        bus_if.funct3 = 3'd0;
        bus_if.funct7b5 = 1'b0;
        bus_if.zero = 1'b0;
        bus_if.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        doReset();

        applyStimulus(OPC_R, 3'b000, 1'b0, 1'b0, 0, 0, "add");
        applyStimulus(OPC_R, 3'b000, 1'b1, 1'b0, 0, 0, "sub");
        applyStimulus(OPC_I, 3'b000, 1'b1, 1'b0, 0, 0, "addi_b30");
        applyStimulus(OPC_I, 3'b010, 1'b0, 1'b0, 0, 0, "slti");
        applyStimulus(OPC_LOAD, 3'b010, 1'b0, 1'b0, 0, 2, "lw_stall2");
        applyStimulus(OPC_BRANCH, 3'b001, 1'b0, 1'b0, 0, 0, "bne_taken");
        applyStimulus(OPC_BRANCH, 3'b001, 1'b0, 1'b1, 0, 0, "bne_not_taken");
        applyStimulus(OPC_JAL, 3'b000, 1'b0, 1'b0, 1, 0, "jal");
        applyStimulus(OPC_STORE, 3'b010, 1'b0, 1'b0, 2, 1, "sw");
        applyStimulus(OPC_SYSTEM, 3'b000, 1'b0, 1'b0, 0, 0, "ill_system");
        applyStimulus(OPC_R, 3'b001, 1'b0, 1'b0, 0, 0, "ill_r_f3");
        swResetTest();

        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 9);
            f3 = 3'($urandom_range(0, 7));
            case (kind)
                0: op = OPC_LOAD;
                1: op = OPC_STORE;
                2, 3: begin op = OPC_R; f3 = alu_f3[$urandom_range(0, 3)]; end
                4, 5: begin op = OPC_I; f3 = alu_f3[$urandom_range(0, 3)]; end
                6: begin op = OPC_BRANCH; f3 = br_f3[$urandom_range(0, 5)]; end
                7: op = OPC_JAL;
                8: begin
                    sub = $urandom_range(0, 3);
                    if (sub == 0) op = OPC_SYSTEM;
                    else if (sub == 1) begin op = OPC_R; f3 = bad_f3[$urandom_range(0, 3)]; end
                    else if (sub == 2) begin op = OPC_I; f3 = bad_f3[$urandom_range(0, 3)]; end
                    else begin op = OPC_BRANCH; f3 = 3'($urandom_range(2, 3)); end
                end
                default: op = 7'($urandom_range(0, 127));
            endcase
            applyStimulus(op, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          $urandom_range(0, 2), $urandom_range(0, 3), $sformatf("rnd%0d", n));
        end

        repeat (2) @(posedge clk);
        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
